// File: rtl/prime_sequencer.sv
// Sequential prime generator: sweeps candidates 2..2^WIDTH-1, tests each by trial division
// (remainder by repeated subtraction) and streams the primes out over a valid/ready handshake.
module prime_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
  output logic [WIDTH-1:0] prime_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prime_count
);

  localparam int unsigned CW = WIDTH + 1;      // candidate width, one spare bit so cand never wraps
  localparam int unsigned PW = 2 * WIDTH + 2;  // width of the d*d product

  localparam logic [CW-1:0] MaxCand = {1'b0, {WIDTH{1'b1}}};
  localparam logic [CW-1:0] Two     = CW'(2);

  typedef enum logic [2:0] {
    StIdle,
    StNext,
    StTest,
    StMod,
    StEmit,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cand_q, cand_d;
  logic [CW-1:0]    div_q, div_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] prime_out_q, prime_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic [PW-1:0] div_ext;
  logic [PW-1:0] div_sq;
  logic [PW-1:0] cand_ext;

  assign div_ext  = PW'(div_q);
  assign div_sq   = div_ext * div_ext;
  assign cand_ext = PW'(cand_q);

  // State register and datapath flops; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cand_q      <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      prime_out_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      prime_out_q <= prime_out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic: trial division sweep plus output handshake.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    div_d       = div_q;
    rem_d       = rem_q;
    prime_out_d = prime_out_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    count_d     = count_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cand_d  = Two;
          count_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StNext;
        end
      end
      StNext: begin
        div_d = Two;
        if (cand_q > MaxCand) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StTest;
        end
      end
      StTest: begin
        if (div_sq > cand_ext) begin
          // No divisor up to sqrt(cand): it is prime, present it next cycle.
          prime_out_d = cand_q[WIDTH-1:0];
          valid_d     = 1'b1;
          state_d     = StEmit;
        end else begin
          rem_d   = cand_q;
          state_d = StMod;
        end
      end
      StMod: begin
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
        end else if (rem_q == '0) begin
          cand_d  = cand_q + CW'(1);
          state_d = StNext;
        end else begin
          div_d   = div_q + CW'(1);
          state_d = StTest;
        end
      end
      StEmit: begin
        if (ready) begin
          valid_d = 1'b0;
          count_d = count_q + WIDTH'(1);
          cand_d  = cand_q + CW'(1);
          state_d = StNext;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign prime_out   = prime_out_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign prime_count = count_q;

endmodule
